// File: rtl/ipad_sync_debounce.sv
// Pad input conditioner: multi-flop synchroniser, counter-based debouncer with
// registered rise/fall pulses, and a saturating counter of rejected glitches.
module ipad_sync_debounce #(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 4,
  parameter logic RESET_VAL     = 1'b0,
  parameter int   GLITCH_W      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inpad,
  input  logic                clr_glitch,
  output logic                q,
  output logic                rise,
  output logic                fall,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic {STABLE, PENDING} state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   q_q;
  logic                   rise_q;
  logic                   fall_q;
  logic [GLITCH_W-1:0]    glitch_q;
  logic                   reject;

  // Plain shift chain: nothing may sit between stages, or metastability could leak.
  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {SYNC_STAGES{RESET_VAL}};
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], inpad};
  end

  assign s      = sync_q[SYNC_STAGES-1];
  assign reject = (state_q == PENDING) && (s == q_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= STABLE;
      cnt_q    <= '0;
      q_q      <= RESET_VAL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        STABLE: begin
          if (s != q_q) begin
            if (STABLE_CYCLES == 1) begin
              q_q    <= s;
              rise_q <= s;
              fall_q <= ~s;
            end else begin
              state_q <= PENDING;
              cnt_q   <= CNT_W'(1);
            end
          end
        end
        PENDING: begin
          if (s != q_q) begin
            if (cnt_q == CNT_LAST) begin
              q_q     <= s;
              rise_q  <= s;
              fall_q  <= ~s;
              cnt_q   <= '0;
              state_q <= STABLE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_q   <= '0;
            state_q <= STABLE;
          end
        end
        default: begin
          state_q <= STABLE;
          cnt_q   <= '0;
        end
      endcase

      // Clear wins over a coincident reject; the counter holds at all-ones.
      if (clr_glitch)                  glitch_q <= '0;
      else if (reject && glitch_q != '1) glitch_q <= glitch_q + GLITCH_W'(1);
    end
  end

  assign q          = q_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_ipad_sync_debounce.sv
// Bench for ipad_sync_debounce: directed pad waveforms on four parameterisations,
// with expected edge pulses queued by the driver and matched by a monitor.
module tb_ipad_sync_debounce;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance: default parameters
  logic       inpad_m = 1'b0, clr_m = 1'b0, q_m, rise_m, fall_m;
  logic [7:0] glitch_m;
  // RESET_VAL = 1
  logic       inpad_r = 1'b1, q_r, rise_r, fall_r;
  logic [7:0] glitch_r;
  // GLITCH_W = 2
  logic       inpad_g = 1'b0, clr_g = 1'b0, q_g, rise_g, fall_g;
  logic [1:0] glitch_g;
  // STABLE_CYCLES = 1
  logic       inpad_n = 1'b0, q_n, rise_n, fall_n;
  logic [7:0] glitch_n;

  ipad_sync_debounce u_main (
    .clk(clk), .rst_n(rst_n), .inpad(inpad_m), .clr_glitch(clr_m),
    .q(q_m), .rise(rise_m), .fall(fall_m), .glitch_cnt(glitch_m));

  ipad_sync_debounce #(.RESET_VAL(1'b1)) u_rv1 (
    .clk(clk), .rst_n(rst_n), .inpad(inpad_r), .clr_glitch(1'b0),
    .q(q_r), .rise(rise_r), .fall(fall_r), .glitch_cnt(glitch_r));

  ipad_sync_debounce #(.GLITCH_W(2)) u_gw2 (
    .clk(clk), .rst_n(rst_n), .inpad(inpad_g), .clr_glitch(clr_g),
    .q(q_g), .rise(rise_g), .fall(fall_g), .glitch_cnt(glitch_g));

  ipad_sync_debounce #(.STABLE_CYCLES(1)) u_n1 (
    .clk(clk), .rst_n(rst_n), .inpad(inpad_n), .clr_glitch(1'b0),
    .q(q_n), .rise(rise_n), .fall(fall_n), .glitch_cnt(glitch_n));

  typedef struct {
    bit is_rise;
    int cyc;
  } ev_t;

  ev_t exp_m[$];
  ev_t exp_n[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_ev(input string tag, input ev_t ev, input logic r, input logic qv);
    check({tag, " pulse kind (1=rise)"}, 32'(r), 32'(ev.is_rise));
    check({tag, " pulse cycle"}, cyc, ev.cyc);
    check({tag, " q at pulse"}, 32'(qv), 32'(ev.is_rise));
  endtask

  // Monitor: every pulse seen must match the oldest queued expectation.
  always @(negedge clk) begin
    ev_t ev;
    if (rise_m || fall_m) begin
      check("main rise&fall exclusive", 32'(rise_m & fall_m), 0);
      check("main pulse was expected", 32'(exp_m.size() > 0), 1);
      if (exp_m.size() > 0) begin
        ev = exp_m.pop_front();
        check_ev("main", ev, rise_m, q_m);
      end
    end
    if (rise_n || fall_n) begin
      check("n1 rise&fall exclusive", 32'(rise_n & fall_n), 0);
      check("n1 pulse was expected", 32'(exp_n.size() > 0), 1);
      if (exp_n.size() > 0) begin
        ev = exp_n.pop_front();
        check_ev("n1", ev, rise_n, q_n);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_m(input bit is_rise, input int lat);
    exp_m.push_back('{is_rise: is_rise, cyc: cyc + lat});
  endtask

  task automatic glitch_main(input int len);
    inpad_m = 1'b1;
    step(len);
    inpad_m = 1'b0;
    step(10);
  endtask

  initial begin
    // Reset held with a busy pad: outputs must stay at reset values.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #2 inpad_m = ~inpad_m;
      @(negedge clk);
      check("reset q", 32'(q_m), 0);
      check("reset rise|fall", 32'(rise_m | fall_m), 0);
      check("reset glitch_cnt", 32'(glitch_m), 0);
      check("reset q RESET_VAL=1", 32'(q_r), 1);
    end
    inpad_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(4);
    check("idle q after release", 32'(q_m), 0);

    // Clean rise then fall, 6-edge latency each.
    inpad_m = 1'b1;
    push_m(1'b1, 6);
    step(10);
    check("clean rise q", 32'(q_m), 1);
    check("clean rise glitch_cnt", 32'(glitch_m), 0);
    inpad_m = 1'b0;
    push_m(1'b0, 6);
    step(10);
    check("clean fall q", 32'(q_m), 0);

    // Short highs are rejected and counted; a 4-cycle high is accepted.
    glitch_main(2);
    check("glitch2 q", 32'(q_m), 0);
    check("glitch2 count", 32'(glitch_m), 1);
    glitch_main(3);
    check("glitch3 q", 32'(q_m), 0);
    check("glitch3 count", 32'(glitch_m), 2);
    inpad_m = 1'b1;
    push_m(1'b1, 6);
    step(4);
    inpad_m = 1'b0;
    push_m(1'b0, 6);
    step(1);
    check("4-cycle high not yet accepted", 32'(q_m), 0);
    step(1);
    check("4-cycle high accepted", 32'(q_m), 1);
    step(10);
    check("after 4-cycle high q", 32'(q_m), 0);
    check("after 4-cycle high count", 32'(glitch_m), 2);

    // Saturation at 2 bits, then clear coincident with a reject.
    for (int i = 0; i < 5; i++) begin
      inpad_g = 1'b1;
      step(2);
      inpad_g = 1'b0;
      step(8);
    end
    check("gw2 saturated count", 32'(glitch_g), 3);
    check("gw2 q", 32'(q_g), 0);
    inpad_g = 1'b1;
    step(2);
    inpad_g = 1'b0;
    step(2);
    clr_g = 1'b1;
    step(1);
    clr_g = 1'b0;
    check("gw2 clear beats reject", 32'(glitch_g), 0);
    step(4);
    check("gw2 count stays cleared", 32'(glitch_g), 0);

    // Reset mid-PENDING discards the change; full latency after release.
    inpad_m = 1'b1;
    step(4);
    rst_n = 1'b0;
    step(2);
    check("mid-pending reset q", 32'(q_m), 0);
    check("mid-pending reset rise", 32'(rise_m), 0);
    @(negedge clk);
    rst_n = 1'b1;
    push_m(1'b1, 6);
    step(4);
    check("post-reset q before latency", 32'(q_m), 0);
    step(6);
    check("post-reset q", 32'(q_m), 1);
    check("post-reset glitch_cnt", 32'(glitch_m), 0);
    inpad_m = 1'b0;
    push_m(1'b0, 6);
    step(10);

    // STABLE_CYCLES=1: a one-cycle pad pulse passes straight through.
    inpad_n = 1'b1;
    exp_n.push_back('{is_rise: 1'b1, cyc: cyc + 3});
    exp_n.push_back('{is_rise: 1'b0, cyc: cyc + 4});
    step(1);
    inpad_n = 1'b0;
    step(6);
    check("n1 q final", 32'(q_n), 0);
    check("n1 glitch_cnt", 32'(glitch_n), 0);

    check("main expected pulses outstanding", exp_m.size(), 0);
    check("n1 expected pulses outstanding", exp_n.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
